// File: rtl/sha_pkg.sv
// Shared types and sigma helpers for the SHA-256 message schedule.
// Optional perf counters in the sequencer are enabled by SHA_SCHED_PERF_EN.
package sha_pkg;

    localparam int SHA256_ROUNDS = 64;

    typedef logic [31:0] word_t;
    typedef logic [15:0][31:0] block_t;

    typedef enum logic {
        IDLE,
        RUN
    } sched_state_e;

    function automatic word_t sigma0(word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic word_t sigma1(word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha_sched_next_word.sv
// Combinational expansion of the next schedule word from the sliding window.
module sha_sched_next_word
    import sha_pkg::*;
(
    input  word_t q0,
    input  word_t q1,
    input  word_t q9,
    input  word_t q14,
    output word_t nw
);

    assign nw = sigma1(q14) + q9 + sigma0(q1) + q0;

endmodule

// File: rtl/sha_message_schedule_sequencer.sv
// Streams W_0..W_63 of a 512-bit block through a 16-word sliding window.
// Define SHA_SCHED_PERF_EN to add block and stall counters.
module sha_message_schedule_sequencer
    import sha_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              blk_valid_i,
    output logic              blk_ready_o,
    input  block_t            blk_i,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [WORD_W-1:0] w_o,
    output logic [5:0]        t_o,
`ifdef SHA_SCHED_PERF_EN
    output logic [31:0]       blk_count_o,
    output logic [31:0]       stall_count_o,
`endif
    output logic              last_o
);

    if (ROUNDS != SHA256_ROUNDS || WORD_W != 32) begin : g_bad_cfg
        $error("sha_message_schedule_sequencer: ROUNDS must be 64, WORD_W 32");
    end

    sched_state_e state;
    block_t       q;
    logic [5:0]   t;
    word_t        nw;
    logic         hs;
    logic         at_last;

    sha_sched_next_word u_next (
        .q0  (q[0]),
        .q1  (q[1]),
        .q9  (q[9]),
        .q14 (q[14]),
        .nw  (nw)
    );

    assign w_valid_o   = (state == RUN);
    assign w_o         = q[0];
    assign t_o         = t;
    assign at_last     = (state == RUN) && (t == 6'd63);
    assign last_o      = at_last;
    assign hs          = w_valid_o && w_ready_i;
    assign blk_ready_o = (state == IDLE) || (at_last && w_ready_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            t     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (blk_valid_i) begin
                        q     <= blk_i;
                        t     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        if (at_last) begin
                            // Back-to-back load keeps RUN with no bubble
                            t <= '0;
                            if (blk_valid_i) begin
                                q <= blk_i;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            q <= {nw, q[15:1]};
                            t <= t + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SHA_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_o   <= '0;
            stall_count_o <= '0;
        end else begin
            if (hs && at_last) begin
                blk_count_o <= blk_count_o + 32'd1;
            end
            if (w_valid_o && !w_ready_i && stall_count_o != 32'hFFFF_FFFF) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sha_message_schedule_sequencer.sv
// Scoreboard bench for the SHA-256 message schedule sequencer.
module tb_sha_message_schedule_sequencer;
    import sha_pkg::*;

    typedef struct {
        logic [31:0] w;
        logic [5:0]  t;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        blk_valid_i;
    logic        blk_ready_o;
    block_t      blk_i;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [31:0] w_o;
    logic [5:0]  t_o;
    logic        last_o;
`ifdef SHA_SCHED_PERF_EN
    logic [31:0] blk_count_o;
    logic [31:0] stall_count_o;
`endif

    int   checks = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   stalls = 0;
    int   blocks = 0;
    int   ready_mode = 0;
    int   hold = 0;
    logic have_prev = 1'b0;
    logic [31:0] prev_w;
    logic [5:0]  prev_t;
    logic        prev_last;

    sha_message_schedule_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .blk_valid_i   (blk_valid_i),
        .blk_ready_o   (blk_ready_o),
        .blk_i         (blk_i),
        .w_valid_o     (w_valid_o),
        .w_ready_i     (w_ready_i),
        .w_o           (w_o),
        .t_o           (t_o),
`ifdef SHA_SCHED_PERF_EN
        .blk_count_o   (blk_count_o),
        .stall_count_o (stall_count_o),
`endif
        .last_o        (last_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference schedule: textbook recurrence over a full 64-entry array
    function automatic void push_block(block_t b);
        logic [31:0] w[64];
        logic [31:0] s0, s1;
        exp_t e;
        for (int i = 0; i < 16; i++) w[i] = b[i];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) begin
            e.w = w[i];
            e.t = 6'(i);
            e.last = (i == 63);
            sbq.push_back(e);
        end
    endfunction

    function automatic block_t rand_block();
        block_t b;
        for (int i = 0; i < 16; i++) b[i] = $urandom;
        return b;
    endfunction

    // Acceptance: a block taken this cycle queues its 64 expected words
    always @(negedge clk) begin
        if (rst_n && blk_valid_i && blk_ready_o) push_block(blk_i);
    end

    // Monitor: compares each handshaken word and stall stability
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (w_valid_o) begin
                if (have_prev) begin
                    chk("stall_w_stable", w_o, prev_w);
                    chk("stall_t_stable", 32'(t_o), 32'(prev_t));
                    chk("stall_last_stable", 32'(last_o), 32'(prev_last));
                end
                if (w_ready_i) begin
                    have_prev = 1'b0;
                    if (sbq.size() == 0) begin
                        chk("unexpected_word", 32'(t_o), 32'hFFFF_FFFF);
                    end else begin
                        e = sbq.pop_front();
                        chk("w", w_o, e.w);
                        chk("t", 32'(t_o), 32'(e.t));
                        chk("last", 32'(last_o), 32'(e.last));
                        chk("blk_ready_hs", 32'(blk_ready_o), 32'(e.last));
                        if (e.last) blocks++;
                    end
                end else begin
                    chk("blk_ready_stall", 32'(blk_ready_o), 32'd0);
                    prev_w = w_o;
                    prev_t = t_o;
                    prev_last = last_o;
                    have_prev = 1'b1;
                    stalls++;
                end
            end else begin
                have_prev = 1'b0;
            end
        end
    end

    // Downstream ready: 0 always, 1 random 50%, 2 stall W_63 for 10 cycles
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            w_ready_i = 1'($urandom_range(0, 1));
        end else if (ready_mode == 2 && w_valid_o && t_o == 6'd63 && hold < 10) begin
            w_ready_i = 1'b0;
            hold++;
        end else begin
            w_ready_i = 1'b1;
        end
    end

    task automatic send_block(input block_t b, output logic [5:0] acc_t);
        int n = 0;
        blk_i = b;
        blk_valid_i = 1'b1;
        acc_t = '0;
        forever begin
            @(negedge clk);
            if (blk_ready_o) begin
                acc_t = t_o;
                break;
            end
            n++;
            if (n > 400) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1 blk_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (!w_valid_o && sbq.size() == 0) break;
            n++;
            if (n > 1000) begin
                chk("idle_timeout", 32'(sbq.size()), 32'd0);
                break;
            end
        end
    endtask

    task automatic wait_t(input logic [5:0] tt, input logic need_hs);
        int n = 0;
        forever begin
            @(negedge clk);
            if (w_valid_o && t_o == tt && (w_ready_i || !need_hs)) break;
            n++;
            if (n > 1000) begin
                chk("wait_t_timeout", 32'(t_o), 32'(tt));
                break;
            end
        end
    endtask

    task automatic check_perf();
`ifdef SHA_SCHED_PERF_EN
        chk("blk_count", blk_count_o, 32'(blocks));
        chk("stall_count", stall_count_o, 32'(stalls));
`endif
    endtask

    initial begin
        block_t      b;
        logic [5:0]  acc;
        #500000;
        $display("FAIL watchdog sbq=%0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        block_t     b;
        logic [5:0] acc;
        rst_n = 1'b0;
        blk_valid_i = 1'b0;
        blk_i = '0;
        w_ready_i = 1'b1;
        @(negedge clk);
        chk("rst_w_valid", 32'(w_valid_o), 32'd0);
        chk("rst_w", w_o, 32'd0);
        chk("rst_t", 32'(t_o), 32'd0);
        chk("rst_last", 32'(last_o), 32'd0);
        check_perf();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(blk_ready_o), 32'd1);

        // abc block
        b = '0;
        b[0] = 32'h61626380;
        b[15] = 32'h00000018;
        send_block(b, acc);
        wait_t(6'd16, 1'b1);
        chk("abc_w16", w_o, 32'h61626380);
        wait_t(6'd17, 1'b1);
        chk("abc_w17", w_o, 32'h000F0000);
        wait_t(6'd18, 1'b1);
        chk("abc_w18", w_o, 32'h7DA86405);
        wait_idle();
        check_perf();

        // backpressure
        ready_mode = 1;
        for (int k = 0; k < 2; k++) begin
            send_block(rand_block(), acc);
            wait_idle();
        end
        check_perf();

        // back-to-back
        ready_mode = 0;
        send_block(rand_block(), acc);
        send_block(rand_block(), acc);
        chk("b2b_accept_t", 32'(acc), 32'd63);
        @(negedge clk);
        chk("b2b_w0_valid", 32'(w_valid_o), 32'd1);
        chk("b2b_w0_t", 32'(t_o), 32'd0);
        wait_idle();
        check_perf();

        // ready gating during RUN
        send_block(rand_block(), acc);
        wait_t(6'd5, 1'b0);
        blk_i = rand_block();
        blk_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("gate_ready", 32'(blk_ready_o), 32'd0);
            @(negedge clk);
        end
        blk_valid_i = 1'b0;
        wait_idle();

        // stalled last word
        ready_mode = 2;
        hold = 0;
        send_block(rand_block(), acc);
        wait_idle();
        chk("t63_hold", 32'(hold), 32'd10);
        check_perf();
        ready_mode = 0;

        // reset mid-block
        send_block(rand_block(), acc);
        wait_t(6'd30, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(w_valid_o), 32'd0);
        sbq.delete();
        have_prev = 1'b0;
        blocks = 0;
        stalls = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(blk_ready_o), 32'd1);
        check_perf();
        send_block('0, acc);
        wait_idle();
        check_perf();

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
